// File: rtl/disp_scan.sv
// disp_scan: 4-digit multiplexed 7-segment scanner with double-buffered
// digit data, per-slot anti-ghosting blank phase and optional leading-zero
// suppression on the upper two digits.
module disp_scan #(
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [6:0] seg,
  output logic [3:0] dig,
  output logic       frame
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [1:0]    r_idx;
  logic [1:0]    w_idx_next;
  logic [7:0]    r_shadow_lo;
  logic [7:0]    r_shadow_hi;
  logic [7:0]    r_active_lo;
  logic [7:0]    r_active_hi;
  logic [1:0]    r_ctrl;
  logic          r_frame;

  logic          w_wr_lo;
  logic          w_wr_hi;
  logic          w_wr_ctrl;
  logic [7:0]    w_lo_next;
  logic [7:0]    w_hi_next;
  logic          w_disable;
  logic          w_last;
  logic          w_boundary;
  logic          w_copy;
  logic [3:0]    w_nib;
  logic          w_suppress;
  logic [6:0]    w_seg_dec;

  // Register write decode; STATUS (addr 3) has no write path
  assign w_wr_lo   = wr && (addr == 2'd0);
  assign w_wr_hi   = wr && (addr == 2'd1);
  assign w_wr_ctrl = wr && (addr == 2'd2);
  // Shadow values as they will be after this edge, so a same-cycle write lands in the copy
  assign w_lo_next = w_wr_lo ? data_in : r_shadow_lo;
  assign w_hi_next = w_wr_hi ? data_in : r_shadow_hi;
  // Clearing EN overrides whatever the scan would otherwise do this edge
  assign w_disable = w_wr_ctrl && !data_in[0];
  assign w_last     = (r_cnt == CW'(PRESCALE - 1));
  assign w_boundary = (r_state == ST_SHOW) && w_last && (r_idx == 2'd3);
  assign w_copy     = (r_state == ST_OFF) || w_boundary;

  // Next-state logic for the scan sequencer (state, slot counter, digit index)
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    case (r_state)
      ST_OFF: begin
        w_cnt_next = '0;
        w_idx_next = 2'd0;
        if (r_ctrl[0]) w_state_next = ST_BLANK;
      end
      ST_BLANK: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == CW'(BLANK - 1)) w_state_next = ST_SHOW;
      end
      ST_SHOW: begin
        if (w_last) begin
          w_cnt_next   = '0;
          w_idx_next   = r_idx + 2'd1;
          w_state_next = ST_BLANK;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_OFF;
        w_cnt_next   = '0;
        w_idx_next   = 2'd0;
      end
    endcase
    if (w_disable) begin
      w_state_next = ST_OFF;
      w_cnt_next   = '0;
      w_idx_next   = 2'd0;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  // Host registers, shadow-to-active copy and the registered frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_lo <= 8'h00;
      r_shadow_hi <= 8'h00;
      r_active_lo <= 8'h00;
      r_active_hi <= 8'h00;
      r_ctrl      <= 2'b00;
      r_frame     <= 1'b0;
    end else begin
      r_shadow_lo <= w_lo_next;
      r_shadow_hi <= w_hi_next;
      if (w_wr_ctrl) r_ctrl <= data_in[1:0];
      if (w_copy) begin
        r_active_lo <= w_lo_next;
        r_active_hi <= w_hi_next;
      end
      r_frame <= w_boundary && !w_disable;
    end
  end

  // Combinational readback; DATA reads return the shadow copy
  always_comb begin
    data_out = 8'h00;
    case (addr)
      2'd0:    data_out = r_shadow_lo;
      2'd1:    data_out = r_shadow_hi;
      2'd2:    data_out = {6'b0, r_ctrl};
      default: data_out = {5'b0, (r_state != ST_OFF), r_idx};
    endcase
  end

  // Select the active nibble for the current digit and decide zero suppression
  always_comb begin
    w_nib = 4'h0;
    case (r_idx)
      2'd0:    w_nib = r_active_lo[3:0];
      2'd1:    w_nib = r_active_lo[7:4];
      2'd2:    w_nib = r_active_hi[3:0];
      default: w_nib = r_active_hi[7:4];
    endcase
    w_suppress = r_ctrl[1] &&
                 (((r_idx == 2'd3) && (r_active_hi[7:4] == 4'h0)) ||
                  ((r_idx == 2'd2) && (r_active_hi == 8'h00)));
  end

  // Nibble to segment pattern
  always_comb begin
    w_seg_dec = 7'b0000000;
    case (w_nib)
      4'h0: w_seg_dec = 7'b1110111;
      4'h1: w_seg_dec = 7'b0100100;
      4'h2: w_seg_dec = 7'b1011101;
      4'h3: w_seg_dec = 7'b1101101;
      4'h4: w_seg_dec = 7'b0101110;
      4'h5: w_seg_dec = 7'b1101011;
      4'h6: w_seg_dec = 7'b1111011;
      4'h7: w_seg_dec = 7'b0100111;
      4'h8: w_seg_dec = 7'b1111111;
      4'h9: w_seg_dec = 7'b1101111;
      4'hA: w_seg_dec = 7'b0111111;
      4'hB: w_seg_dec = 7'b1111010;
      4'hC: w_seg_dec = 7'b1010011;
      4'hD: w_seg_dec = 7'b1111100;
      4'hE: w_seg_dec = 7'b1011011;
      default: w_seg_dec = 7'b0011011;
    endcase
  end

  // Display outputs are derived from registered state only
  assign seg   = ((r_state == ST_OFF) || w_suppress) ? 7'b0000000 : w_seg_dec;
  assign frame = r_frame;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dig
      assign dig[gi] = (r_state == ST_SHOW) && (r_idx == 2'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with PRESCALE=8, BLANK=2 (32-cycle frames).
module tb_disp_scan;

  logic       clk;
  logic       rst;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [6:0] seg;
  logic [3:0] dig;
  logic       frame;

  int n_total = 0;
  int n_bad   = 0;

  disp_scan #(.PRESCALE(8), .BLANK(2)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .seg      (seg),
    .dig      (dig),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s t=%0t got=0x%0h want=0x%0h", tag, $time, obs, exp_v);
    end
  endtask

  // Called at a negedge; the write is taken on the following posedge
  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    addr    = a;
    data_in = d;
    wr      = 1'b1;
    @(negedge clk);
    wr      = 1'b0;
    $display("write addr=%0d data=0x%02h t=%0t", a, d, $time);
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input logic [7:0] exp_v);
    addr = a;
    #1;
    chk(tag, data_out, exp_v);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (!frame && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("frame_wait", frame, 1'b1);
  endtask

  // Starts on the negedge where frame is high; checks 32 cycles of one frame
  task automatic scan_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] sv [4];
    int idx;
    int cnt;
    logic [3:0] exp_dig;
    sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
    for (int c = 0; c < 32; c++) begin
      if (c != 0) @(negedge clk);
      idx = c / 8;
      cnt = c % 8;
      exp_dig = (cnt >= 2) ? (4'b0001 << idx) : 4'b0000;
      chk("scan_dig", dig, exp_dig);
      chk("scan_seg", seg, sv[idx]);
      chk("scan_frame", frame, (c == 0));
    end
    $display("frame checked segs=%02h %02h %02h %02h t=%0t", s0, s1, s2, s3, $time);
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; addr = 2'd0; data_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_seg", seg, 7'h00);
    chk("rst_dig", dig, 4'h0);
    chk("rst_frame", frame, 1'b0);
    for (int a = 0; a < 4; a++) read_chk("rst_rd", 2'(a), 8'h00);
    rst = 1'b0;

    // STATUS is read-only; the write must not alter anything
    reg_write(2'd3, 8'hFF);
    read_chk("status_ro", 2'd3, 8'h00);
    read_chk("ctrl_untouched", 2'd2, 8'h00);

    reg_write(2'd0, 8'h21);
    reg_write(2'd1, 8'h43);
    read_chk("rd_lo", 2'd0, 8'h21);
    read_chk("rd_hi", 2'd1, 8'h43);

    // Enable: OFF one more cycle, then BLANK x2, then SHOW digit0
    reg_write(2'd2, 8'h01);
    read_chk("start_status_off", 2'd3, 8'h00);
    chk("start_dig_off", dig, 4'h0);
    @(negedge clk);
    read_chk("start_status_run", 2'd3, 8'h04);
    chk("start_dig_blank", dig, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("start_dig_show", dig, 4'h1);
    chk("start_seg_show", seg, 7'h24);

    wait_frame();
    scan_frame(7'h24, 7'h5D, 7'h6D, 7'h2E);
    @(negedge clk);
    chk("frame_period", frame, 1'b1);
    scan_frame(7'h24, 7'h5D, 7'h6D, 7'h2E);

    // Mid-frame DATA_LO write: readback at once, display only after the frame
    @(negedge clk);
    repeat (3) @(negedge clk);
    reg_write(2'd0, 8'hFF);
    read_chk("shadow_rd", 2'd0, 8'hFF);
    chk("seg_hold", seg, 7'h24);
    wait_frame();
    scan_frame(7'h1B, 7'h1B, 7'h6D, 7'h2E);

    // Write landing exactly on the frame-boundary edge is in the copy
    reg_write(2'd1, 8'h00);
    scan_frame(7'h1B, 7'h1B, 7'h77, 7'h77);

    // Zero suppression; re-writing EN=1 must not restart the scan
    @(negedge clk);
    reg_write(2'd1, 8'h05);
    reg_write(2'd2, 8'hFF);
    chk("no_restart", dig, 4'h1);
    read_chk("ctrl_rd", 2'd2, 8'h03);
    wait_frame();
    scan_frame(7'h1B, 7'h1B, 7'h6B, 7'h00);
    @(negedge clk);
    reg_write(2'd0, 8'h00);
    reg_write(2'd1, 8'h00);
    wait_frame();
    scan_frame(7'h77, 7'h77, 7'h00, 7'h00);

    // Disable mid-SHOW, then re-enable
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("pre_off_dig", dig, 4'h1);
    reg_write(2'd2, 8'h00);
    chk("off_dig", dig, 4'h0);
    chk("off_seg", seg, 7'h00);
    chk("off_frame", frame, 1'b0);
    read_chk("off_status", 2'd3, 8'h00);
    reg_write(2'd2, 8'h01);
    read_chk("reen_status_off", 2'd3, 8'h00);
    @(negedge clk);
    read_chk("reen_status_run", 2'd3, 8'h04);
    chk("reen_dig_blank0", dig, 4'h0);
    @(negedge clk);
    chk("reen_dig_blank1", dig, 4'h0);
    @(negedge clk);
    chk("reen_dig_show", dig, 4'h1);
    chk("reen_seg_show", seg, 7'h77);

    // Reset mid-scan with a simultaneous write
    reg_write(2'd0, 8'h5A);
    repeat (4) @(negedge clk);
    rst = 1'b1; wr = 1'b1; addr = 2'd0; data_in = 8'hAA;
    @(negedge clk);
    wr = 1'b0;
    chk("rst2_seg", seg, 7'h00);
    chk("rst2_dig", dig, 4'h0);
    chk("rst2_frame", frame, 1'b0);
    for (int a = 0; a < 4; a++) read_chk("rst2_rd", 2'(a), 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_dig", dig, 4'h0);
    chk("post_rst_seg", seg, 7'h00);
    read_chk("post_rst_status", 2'd3, 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter PRESCALE, default 1000: clock cycles per digit slot; legal range is PRESCALE >= BLANK+2.
REQ-002 Parameter BLANK, default 16: cycles at the start of each slot with all digit enables off (anti-ghosting); legal range is BLANK >= 1.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port wr, input, 1 bit: register write strobe, sampled each cycle.
REQ-006 Port addr, input, 2 bits: register select (0 DATA_LO, 1 DATA_HI, 2 CTRL, 3 STATUS).
REQ-007 Port data_in, input, 8 bits: write data.
REQ-008 Port data_out, output, 8 bits: combinational readback of the register selected by addr.
REQ-009 Port seg, output, 7 bits: segment pattern for the active digit, active-high.
REQ-010 Port dig, output, 4 bits: one-hot digit enable, active-high; dig[i] drives digit i.
REQ-011 Port frame, output, 1 bit: one-cycle pulse at each scan-frame boundary.

Function
REQ-012 Registers:
- DATA_LO holds digits 1:0 (bits[3:0] = digit0).
- DATA_HI holds digits 3:2.
- CTRL bit0 is EN and bit1 is ZSUP; CTRL bits[7:2] SHALL read 0.
- STATUS (read-only) is {5'b0, state!=OFF, idx[1:0]}; writes to STATUS SHALL be ignored.
REQ-013 Double buffering: DATA writes go to shadow registers; data_out SHALL return the shadow value; display uses active copies.
REQ-014 Shadow-to-active copy SHALL occur at each frame boundary and on every cycle while state is OFF.
- A same-cycle DATA write SHALL be included in the copy: active gets data_in.
REQ-015 State machine OFF/BLANK/SHOW, state register plus cnt (0..PRESCALE-1) and idx (0..3).
REQ-016 OFF: cnt=0, idx=0, dig=0, seg=0. OFF->BLANK on the cycle after EN reads 1.
REQ-017 BLANK: cnt increments each cycle; dig=0; seg=decoded digit idx.
- At cnt==BLANK-1, transition to SHOW.
REQ-018 SHOW: dig=onehot(idx); seg=decoded digit idx; cnt increments each cycle.
- At cnt==PRESCALE-1: cnt->0, idx->idx+1 mod 4, transition to BLANK.
REQ-019 Frame boundary: the SHOW cycle with cnt==PRESCALE-1 and idx==3.
- frame=1 on the following cycle, for exactly one cycle.
- Active copy updates on that same edge; idx wraps 3->0.
REQ-020 Writing EN=0 in any state SHALL force OFF on the next edge.
- cnt and idx cleared; no frame pulse; shadow contents unchanged.
REQ-021 Writing CTRL with EN=1 while already scanning SHALL NOT restart the scan; ZSUP takes effect immediately.
REQ-022 Segment encoding, nibble -> seg[6:0]:
- 0=1110111, 1=0100100, 2=1011101, 3=1101101
- 4=0101110, 5=1101011, 6=1111011, 7=0100111
- 8=1111111, 9=1101111, A=0111111, B=1111010
- C=1010011, D=1111100, E=1011011, F=0011011
REQ-023 ZSUP=1: digit3 SHALL show seg=0 if its nibble is 0; digit2 SHALL show seg=0 if digits 3 and 2 are both 0; digits 1 and 0 are never suppressed.
REQ-024 seg, dig and frame SHALL depend only on registered state; there is no combinational path from wr, addr or data_in to them.
REQ-025 Scan period SHALL be exactly 4*PRESCALE cycles; dig on-time per digit SHALL be exactly PRESCALE-BLANK cycles.

Reset
REQ-026 rst=1 SHALL clear all registers (shadow, active, CTRL, cnt, idx) and force state OFF on that edge.
REQ-027 During and after reset: seg=0, dig=0, frame=0, data_out=0 for every addr.
REQ-028 rst SHALL take priority over a simultaneous wr.

Verification (PRESCALE=8, BLANK=2)
REQ-029 Reset, write DATA_LO=0x21, DATA_HI=0x43, CTRL=0x01.
- dig sequence 0000 x2, 0001 x6, 0000 x2, 0010 x6, ...; seg shows 1,2,3,4 in turn.
- frame pulses every 32 cycles.
REQ-030 While scanning, write DATA_LO=0xFF mid-frame.
- data_out(addr0)=0xFF immediately; seg for digit0 changes only after the next frame pulse.
REQ-031 Write DATA_HI=0x00 on the exact frame-boundary cycle -> next frame digits 3:2 show 0 (1110111).
REQ-032 ZSUP=1 with DATA_HI=0x05 -> digit3 seg=0000000, digit2 seg=1101011; with DATA_HI=0x00 and DATA_LO=0x00, digits 3 and 2 are blank and digits 1 and 0 show 0.
REQ-033 CTRL=0x00 mid-SHOW -> next cycle dig=0, seg=0, STATUS=0x00; re-enable -> scan restarts at idx 0 with a BLANK phase.
REQ-034 Assert rst mid-scan with wr=1 -> all outputs 0 and all registers 0 on the next cycle; the write is discarded.
